// File: rtl/iterative_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB slice first,
// carrying between slices through a register. WIDTH must be a multiple of CHUNK.
module iterative_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [31:0]      offset;
    logic [CHUNK:0]   slice_add;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    assign offset = 32'(idx_q) * CHUNK;

    // b_q already holds ~b for subtraction, so the top-bit carry-in is
    // recovered from the operand bits and the result bit.
    always_comb begin
        // NOTE: every always_comb output gets a default before any partial
        // update; otherwise the untouched bits would infer a latch.
        sum_d     = sum_q;
        slice_add = {1'b0, a_q[offset +: CHUNK]}
                  + {1'b0, b_q[offset +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        sum_d[offset +: CHUNK] = slice_add[CHUNK-1:0];
        ovf_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ slice_add[CHUNK];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_add[CHUNK];
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= slice_add[CHUNK];
                        ovf_q   <= ovf_d;
                        zero_q  <= (sum_d == '0);
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
